// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Captures the winning word, strobes the transmitter, and reports completion or start timeout.
module uart_tx_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned START_TMO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             done1,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  output logic             owner,
  output logic             arb_busy,
  output logic             tmo_err
);

  localparam int unsigned CW = $clog2(START_TMO) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_valid;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_tmo_err;
  logic             r_arb_busy;

  logic             w_grant;
  logic             w_winner;
  logic             w_done;
  logic             w_tmo;
  logic             w_tx_valid;

  // Next-state and per-cycle event decode
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_grant    = 1'b0;
    w_winner   = r_owner;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    w_tx_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (!tx_busy && (req0 || req1)) begin
          w_grant  = 1'b1;
          // On a tie the requester served last time yields
          w_winner = (req0 && req1) ? ~r_last_owner : req1;
          w_next   = LOAD;
        end
      end
      LOAD: begin
        w_tx_valid = 1'b1;
        w_cnt_next = '0;
        w_next     = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          w_next = WAIT_DONE;
        end else if (r_cnt >= CW'(START_TMO - 1)) begin
          w_tmo  = 1'b1;
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_arb_busy   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_tx_valid <= w_tx_valid;
      r_gnt0     <= w_grant && !w_winner;
      r_gnt1     <= w_grant && w_winner;
      r_done0    <= w_done && !r_owner;
      r_done1    <= w_done && r_owner;
      r_tmo_err  <= w_tmo;
      r_arb_busy <= (w_next != IDLE);
      if (w_grant) begin
        r_tx_data    <= w_winner ? data1 : data0;
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
      end
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign owner    = r_owner;
  assign arb_busy = r_arb_busy;
  assign tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model (pending requests, round-robin memory, frame timing).
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, tx_busy;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] tx_data;
  logic       tx_valid, owner, arb_busy, tmo_err;

  int  npass  = 0;
  int  ntotal = 0;
  bit  m_last;

  uart_tx_arbiter #(.WIDTH(8), .START_TMO(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .data0   (data0),
    .gnt0    (gnt0),
    .done0   (done0),
    .req1    (req1),
    .data1   (data1),
    .gnt1    (gnt1),
    .done1   (done1),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .owner   (owner),
    .arb_busy(arb_busy),
    .tmo_err (tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_gnt0"}, gnt0, 1'b0);
    chk1({tag, "_gnt1"}, gnt1, 1'b0);
    chk1({tag, "_done0"}, done0, 1'b0);
    chk1({tag, "_done1"}, done1, 1'b0);
    chk1({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk8({tag, "_tx_data"}, tx_data, 8'h00);
    chk1({tag, "_owner"}, owner, 1'b0);
    chk1({tag, "_arb_busy"}, arb_busy, 1'b0);
    chk1({tag, "_tmo_err"}, tmo_err, 1'b0);
  endtask

  // One complete frame: grant, start strobe, then transmitter busy after dly cycles
  // for blen cycles, or no busy at all (dly < 0) to provoke the start timeout.
  task automatic run_frame(input bit exp_own, input logic [7:0] exp_data, input int dly,
                           input int blen, input bit drop, input int max_wait, input bit raise1);
    bit got;
    got = 1'b0;
    for (int n = 0; n < max_wait && !got; n++) begin
      tick();
      if (gnt0 || gnt1) got = 1'b1;
    end
    chk1("gnt_seen", got, 1'b1);
    if (!got) return;
    m_last = exp_own;
    chk1("gnt0", gnt0, !exp_own);
    chk1("gnt1", gnt1, exp_own);
    chk1("owner", owner, exp_own);
    chk1("arb_busy_frame", arb_busy, 1'b1);
    if (drop) begin
      if (exp_own) req1 = 1'b0;
      else         req0 = 1'b0;
    end
    tick();
    chk1("tx_valid", tx_valid, 1'b1);
    chk8("tx_data", tx_data, exp_data);
    chk1("gnt_after", gnt0 || gnt1, 1'b0);
    if (dly < 0) begin
      for (int i = 1; i <= 3; i++) begin
        tick();
        chk1("tmo_early", tmo_err, 1'b0);
        chk1("tv_single_tmo", tx_valid, 1'b0);
      end
      tick();
      chk1("tmo_err", tmo_err, 1'b1);
      chk1("done_own_tmo", exp_own ? done1 : done0, 1'b1);
      chk1("done_other_tmo", exp_own ? done0 : done1, 1'b0);
      chk1("arb_idle_tmo", arb_busy, 1'b0);
    end else begin
      for (int i = 0; i < dly; i++) begin
        tick();
        chk1("tv_single", tx_valid, 1'b0);
      end
      tx_busy = 1'b1;
      for (int i = 0; i < blen; i++) begin
        tick();
        if (raise1 && i == blen / 2) req1 = 1'b1;
        chk1("done_early", done0 || done1, 1'b0);
        chk1("gnt_in_frame", gnt0 || gnt1, 1'b0);
        chk8("tx_data_hold", tx_data, exp_data);
        chk1("arb_busy_wd", arb_busy, 1'b1);
      end
      tx_busy = 1'b0;
      tick();
      chk1("done_own", exp_own ? done1 : done0, 1'b1);
      chk1("done_other", exp_own ? done0 : done1, 1'b0);
      chk1("tmo_none", tmo_err, 1'b0);
      chk1("arb_idle", arb_busy, 1'b0);
      chk1("gnt_at_done", gnt0 || gnt1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tx_busy = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  initial begin
    bit         p0, p1, win;
    logic [7:0] d0, d1;
    int         dly, blen;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Single request, busy for 10 cycles
    req0 = 1'b1; data0 = 8'hA5;
    run_frame(1'b0, 8'hA5, 0, 10, 1'b1, 1, 1'b0);

    // Tie with both requests held: first tie after reset goes to requester 0
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    run_frame(1'b0, 8'h11, 1, 3, 1'b0, 1, 1'b0);
    run_frame(1'b1, 8'h22, 1, 3, 1'b0, 1, 1'b0);
    run_frame(1'b0, 8'h11, 2, 2, 1'b0, 1, 1'b0);
    run_frame(1'b1, 8'h22, 0, 4, 1'b0, 1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // Start timeout with tx_busy never rising
    req1 = 1'b1; data1 = 8'($urandom);
    run_frame(1'b1, data1, -1, 0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("no_tv_after_tmo", tx_valid, 1'b0);
      chk1("idle_after_tmo", arb_busy, 1'b0);
    end

    // Busy transmitter blocks arbitration in IDLE
    tx_busy = 1'b1; req0 = 1'b1; data0 = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("blocked_gnt0", gnt0, 1'b0);
      chk1("blocked_arb", arb_busy, 1'b0);
    end
    tx_busy = 1'b0;
    run_frame(1'b0, 8'h5A, 2, 3, 1'b1, 1, 1'b0);

    // Reset during WAIT_DONE aborts without done, round-robin memory restarts
    req1 = 1'b1; data1 = 8'h3C;
    tick();
    chk1("mid_gnt1", gnt1, 1'b1);
    req1 = 1'b0;
    tick();
    chk1("mid_tv", tx_valid, 1'b1);
    tx_busy = 1'b1;
    tick();
    tick();
    chk1("mid_busy", arb_busy, 1'b1);
    rst = 1'b1; tx_busy = 1'b0;
    tick();
    rst = 1'b0; m_last = 1'b1;
    chk_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("no_done_after_rst", done0 || done1, 1'b0);
    end
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hC3; data1 = 8'h96;
    run_frame(1'b0, 8'hC3, 1, 3, 1'b0, 1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // req1 arrives while requester 0 is in WAIT_DONE: served right after done0
    req0 = 1'b1; data0 = 8'h0F; data1 = 8'hF0;
    run_frame(1'b0, 8'h0F, 0, 6, 1'b1, 1, 1'b1);
    run_frame(1'b1, 8'hF0, 1, 2, 1'b1, 1, 1'b0);

    // Randomized traffic against the pending-request / round-robin model
    p0 = 1'b0; p1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    for (int it = 0; it < 40; it++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; d0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; d1 = 8'($urandom); end
      if (!p0 && !p1) begin p0 = 1'b1; d0 = 8'($urandom); end
      req0 = p0; req1 = p1; data0 = d0; data1 = d1;
      win  = (p0 && p1) ? !m_last : p1;
      dly  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 3));
      blen = int'($urandom_range(1, 6));
      run_frame(win, win ? d1 : d0, dly, blen, 1'b1, 1, 1'b0);
      if (win) p1 = 1'b0;
      else     p0 = 1'b0;
      if (p0 && $urandom_range(0, 3) == 0) begin p0 = 1'b0; req0 = 1'b0; end
      if (p1 && $urandom_range(0, 3) == 0) begin p1 = 1'b0; req1 = 1'b0; end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data word width in bits, equal to the UART transmitter data width.
REQ-002 SHALL have parameter START_TMO, default 4, the number of cycles allowed for tx_busy to rise after tx_valid.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req0, input, 1 bit: requester 0 has a word to send; held high until gnt0.
REQ-006 SHALL have port data0, input, WIDTH bits: requester 0 word; stable while req0 is high.
REQ-007 SHALL have port gnt0, output, 1 bit: one-cycle pulse; data0 was captured, and requester 0 may drop req0 or present a new word.
REQ-008 SHALL have port done0, output, 1 bit: one-cycle pulse; requester 0 frame has completed or been aborted.
REQ-009 SHALL have ports req1, data1, gnt1 and done1, identical in direction, width and meaning to the requester-0 ports, for requester 1.
REQ-010 SHALL have port tx_busy, input, 1 bit: busy status from the UART transmitter.
REQ-011 SHALL have port tx_data, output, WIDTH bits: word to the transmitter P_DATA.
REQ-012 SHALL have port tx_valid, output, 1 bit: one-cycle start strobe to the transmitter Data_Valid.
REQ-013 SHALL have port owner, output, 1 bit: index of the requester currently being served.
REQ-014 SHALL have port arb_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port tmo_err, output, 1 bit: one-cycle pulse when the start timeout expires.

Function
REQ-016 SHALL implement the states IDLE, LOAD, WAIT_START and WAIT_DONE.
REQ-017 In IDLE, the block SHALL arbitrate only when tx_busy=0 and at least one req is high.
REQ-018 When arbitrating, the block SHALL grant the sole requester, or on a tie grant the requester not equal to last_owner (round-robin).
REQ-019 On a grant, the block SHALL in the same cycle pulse gnt of the winner, capture the winner's data into the tx_data register, set owner and last_owner to the winner, and transition to LOAD.
REQ-020 In LOAD, the block SHALL assert tx_valid=1 for exactly one cycle, clear the timeout counter, and transition to WAIT_START.
REQ-021 In WAIT_START, if tx_busy=1 the block SHALL go to WAIT_DONE; otherwise it SHALL increment the counter.
REQ-022 In WAIT_START, when the counter reaches START_TMO-1 without tx_busy, the block SHALL pulse tmo_err and the owner's done, then go to IDLE.
REQ-023 In WAIT_DONE, when tx_busy=0 the block SHALL pulse the owner's done and go to IDLE; otherwise it SHALL stay in WAIT_DONE.
REQ-024 tx_data SHALL stay constant from LOAD until the block returns to IDLE; it changes only on a grant.
REQ-025 The block SHALL issue at most one gnt and one done per cycle, and never assert gnt0 and gnt1 together.
REQ-026 A req arriving while arb_busy=1 SHALL be held pending, with no gnt, until the next IDLE arbitration.
REQ-027 The minimum spacing between two tx_valid pulses SHALL be 4 cycles (LOAD, WAIT_START, WAIT_DONE, IDLE).
REQ-028 The counter SHALL be ceil(log2(START_TMO))+1 bits wide and SHALL NOT wrap.
REQ-029 A req dropped before its gnt SHALL be ignored, with no capture and no done.
REQ-030 tx_busy=1 while in IDLE SHALL block all grants.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set state=IDLE, tx_data=0, tx_valid=0, owner=0, last_owner=1, counter=0, and gnt0, gnt1, done0, done1, tmo_err and arb_busy all 0.
REQ-032 An rst asserted mid-frame SHALL abort the frame with no done pulse; requesters re-request after rst is released.
REQ-033 Because last_owner resets to 1, the first tie after reset SHALL go to requester 0.

Verification
REQ-034 Single request: req0=1, data0=0xA5, tx_busy=0. Required: gnt0 pulses at cycle 0; tx_valid=1 with tx_data=0xA5 at cycle 1; a tx_busy model high for 10 cycles gives done0 one cycle after tx_busy falls; owner=0.
REQ-035 Tie: req0 and req1 held continuously, data0=0x11, data1=0x22. Required: tx_data order 0x11, 0x22, 0x11, 0x22; gnt alternates; the gnts are never concurrent.
REQ-036 Start timeout: req1=1, tx_busy tied 0. Required: tmo_err and done1 pulse together 4 cycles after tx_valid; state returns to IDLE; no further tx_valid while req1=0.
REQ-037 Blocked IDLE: tx_busy=1 in IDLE, req0=1. Required: no gnt0 until the cycle after tx_busy=0.
REQ-038 Reset mid-frame: rst=1 for 1 cycle during WAIT_DONE. Required: the next cycle shows all outputs 0, state IDLE and no done; a following tie is granted to requester 0.
REQ-039 Request during a frame: req1 rises while owner=0 is in WAIT_DONE. Required: no gnt1 until after done0, then gnt1 in the first IDLE cycle.
